// File: rtl/ddr_cmd_sched_if.sv
// rtl/ddr_cmd_sched_if.sv - request handshake and CBA FIFO write port of the DDR command scheduler
interface ddr_cmd_sched_if;
  logic        req_valid;
  logic        req_we;
  logic [24:0] req_adr;
  logic        req_ack;
  logic [17:0] cba_din;
  logic        cba_wr;
  logic        cba_full;

  // Requester / FIFO side: drives requests and FIFO status, observes commands
  modport master (
    output req_valid, req_we, req_adr, cba_full,
    input  req_ack, cba_din, cba_wr
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_we, req_adr, cba_full,
    output req_ack, cba_din, cba_wr
  );
endinterface

// File: rtl/ddr_cmd_sched.sv
// rtl/ddr_cmd_sched.sv - DDR init, auto-refresh and closed-page ACT/RW/PRE command sequencer
module ddr_cmd_sched #(
  parameter int INIT_WAIT        = 20000,
  parameter int REFRESH_INTERVAL = 750
) (
  input  logic           clk,
  input  logic           reset_n,
  ddr_cmd_sched_if.slave bus,
  output logic           init_done
);

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd2;
  localparam logic [2:0] S_REF  = 3'd3;
  localparam logic [2:0] S_ACT  = 3'd4;
  localparam logic [2:0] S_RW   = 3'd5;
  localparam logic [2:0] S_PRE  = 3'd6;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] C_MRS   = 3'b000;
  localparam logic [2:0] C_AR    = 3'b001;
  localparam logic [2:0] C_PRE   = 3'b010;
  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_NOP   = 3'b111;

  localparam logic [14:0] WAIT_LOAD = 15'(INIT_WAIT - 1);
  localparam logic [9:0]  REF_LOAD  = 10'(REFRESH_INTERVAL - 1);

  logic [2:0]  state;
  logic [14:0] wait_cnt;
  logic [2:0]  step;
  logic [9:0]  ref_cnt;
  logic        ref_pending;
  logic        ref_wrap;
  logic [1:0]  bank;
  logic        emit;
  logic        push;
  logic [17:0] cmd_word;
  logic        unused_adr_bits;

  // Burst-aligned column: the low two address bits carry no information
  assign unused_adr_bits = ^bus.req_adr[1:0];

  // Command word presented in the current state; NOP outside emitting states
  always_comb begin
    emit     = 1'b1;
    cmd_word = {C_NOP, 15'd0};
    case (state)
      S_INIT: begin
        case (step)
          3'd0:    cmd_word = {C_PRE, 2'b00, 13'h0400};
          3'd1:    cmd_word = {C_MRS, 2'b01, 13'h0000};
          3'd2:    cmd_word = {C_MRS, 2'b00, 13'h0122};
          3'd3:    cmd_word = {C_PRE, 2'b00, 13'h0400};
          3'd4:    cmd_word = {C_AR,  2'b00, 13'h0000};
          3'd5:    cmd_word = {C_AR,  2'b00, 13'h0000};
          default: cmd_word = {C_MRS, 2'b00, 13'h0022};
        endcase
      end
      S_REF:   cmd_word = {C_AR, 2'b00, 13'h0000};
      S_ACT:   cmd_word = {C_ACT, bus.req_adr[24:23], bus.req_adr[22:10]};
      S_RW:    cmd_word = {bus.req_we ? C_WRITE : C_READ, bank, 3'b000, bus.req_adr[9:2], 2'b00};
      S_PRE:   cmd_word = {C_PRE, bank, 13'h0000};
      default: emit = 1'b0;
    endcase
  end

  // A command leaves only when the FIFO can take it; the word is held while stalled
  assign push        = emit & ~bus.cba_full;
  assign bus.cba_wr  = push;
  assign bus.cba_din = cmd_word;
  assign bus.req_ack = push & (state == S_RW);
  assign ref_wrap    = init_done & (ref_cnt == 10'd0);

  // Main sequencer: power-up wait, init steps, then refresh-first request servicing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_WAIT;
      wait_cnt  <= WAIT_LOAD;
      step      <= 3'd0;
      init_done <= 1'b0;
      bank      <= 2'b00;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 15'd0) begin
            state <= S_INIT;
            step  <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt - 15'd1;
          end
        end
        S_INIT: begin
          if (push) begin
            if (step == 3'd6) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        S_IDLE: begin
          if (ref_pending)        state <= S_REF;
          else if (bus.req_valid) state <= S_ACT;
        end
        S_REF: if (push) state <= S_IDLE;
        S_ACT: begin
          if (push) begin
            bank  <= bus.req_adr[24:23];
            state <= S_RW;
          end
        end
        S_RW:    if (push) state <= S_PRE;
        S_PRE:   if (push) state <= S_IDLE;
        default: state <= S_WAIT;
      endcase
    end
  end

  // Refresh timer: held loaded until init completes, then flags a refresh on every wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt     <= REF_LOAD;
      ref_pending <= 1'b0;
    end else begin
      if (!init_done || ref_cnt == 10'd0) ref_cnt <= REF_LOAD;
      else                                ref_cnt <= ref_cnt - 10'd1;
      if (ref_wrap)                       ref_pending <= 1'b1;
      else if (state == S_REF && push)    ref_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// tb/tb_ddr_cmd_sched.sv - self-checking bench for ddr_cmd_sched
module tb_ddr_cmd_sched;
  localparam int IW = 8;
  localparam int RI = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;

  ddr_cmd_sched_if bus();

  ddr_cmd_sched #(.INIT_WAIT(IW), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] w;
    logic        ack;
    int          cyc;
  } push_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int bad_ack = 0;
  bit mon_en = 0;
  push_t mon_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] init_w[7];
  int ar_cyc[$];
  int seq_pos = 0;
  int acks = 0;
  int reqs = 0;
  bit stop_full = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] mk(input int cmd, input int ba, input int a);
    return 18'(cmd * 32768 + ba * 8192 + a);
  endfunction

  function automatic logic [17:0] exp_act(input int adr);
    return mk(3, adr / 8388608, (adr / 1024) % 8192);
  endfunction

  function automatic logic [17:0] exp_rw(input bit we, input int adr);
    return mk(we ? 4 : 5, adr / 8388608, ((adr % 1024) / 4) * 4);
  endfunction

  function automatic logic [17:0] exp_pre(input int adr);
    return mk(2, adr / 8388608, 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && bus.cba_wr) mon_q.push_back('{bus.cba_din, bus.req_ack, cyc});
    if (bus.req_ack && !bus.cba_wr) bad_ack <= bad_ack + 1;
  end

  task automatic drain();
    push_t e;
    while (mon_q.size() > 0) begin
      e = mon_q.pop_front();
      if (e.w == mk(1, 0, 0)) begin
        chk("ar_at_boundary", seq_pos, 0);
        chk("ar_no_ack", e.ack, 0);
        ar_cyc.push_back(e.cyc);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_push", exp_q.size(), 1);
      end else begin
        chk("cmd_word", e.w, exp_q[0]);
        chk("ack_flag", e.ack, seq_pos == 1);
        if (seq_pos == 1 && e.ack) acks++;
        void'(exp_q.pop_front());
        seq_pos = (seq_pos + 1) % 3;
      end
    end
  endtask

  task automatic issue(input bit we, input int adr);
    int t;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = 25'(adr);
    exp_q.push_back(exp_act(adr));
    exp_q.push_back(exp_rw(we, adr));
    exp_q.push_back(exp_pre(adr));
    reqs++;
    t = 0;
    @(negedge clk);
    while (!bus.req_ack && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ack) chk("ack_timeout", bus.req_ack, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      int adr;
      adr = int'($urandom_range(0, 33554431)) & ~3;
      issue(1'($urandom_range(0, 1)), adr);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic init_check();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.cba_wr && n < IW + 10);
    chk("init_wait_cycles", n, IW);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("init_push_wr", bus.cba_wr, 1);
      chk("init_word", bus.cba_din, init_w[k]);
      chk("init_done_low", init_done, 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    chk("init_no_extra_push", bus.cba_wr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int adr;
    int t;
    init_w[0] = mk(2, 0, 'h400);
    init_w[1] = mk(0, 1, 0);
    init_w[2] = mk(0, 0, 'h122);
    init_w[3] = mk(2, 0, 'h400);
    init_w[4] = mk(1, 0, 0);
    init_w[5] = mk(1, 0, 0);
    init_w[6] = mk(0, 0, 'h022);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.cba_full  = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cba_wr", bus.cba_wr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_cba_din", bus.cba_din, mk(7, 0, 0));

    // power-up initialisation
    @(negedge clk);
    reset_n = 1'b1;
    init_check();
    @(posedge clk);
    #1;
    mon_en = 1;

    // directed read
    issue(1'b0, 'h1ABCDEF);
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drain();

    // write stalled by a full FIFO while the WRITE word is presented
    adr = int'($urandom_range(0, 33554431)) & ~3;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_adr   = 25'(adr);
    exp_q.push_back(exp_act(adr));
    exp_q.push_back(exp_rw(1'b1, adr));
    exp_q.push_back(exp_pre(adr));
    reqs++;
    t = 0;
    @(negedge clk);
    while (!(bus.cba_wr && bus.cba_din[17:15] == 3'b011) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_act_seen", bus.cba_din[17:15], 3);
    @(posedge clk);
    #1;
    bus.cba_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wr_low", bus.cba_wr, 0);
      chk("stall_din", bus.cba_din, exp_rw(1'b1, adr));
      chk("stall_ack_low", bus.req_ack, 0);
    end
    @(posedge clk);
    #1;
    bus.cba_full = 1'b0;
    @(negedge clk);
    chk("stall_push", bus.cba_wr, 1);
    chk("stall_ack", bus.req_ack, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drain();

    // back-to-back requests with refresh interleaving
    ar_cyc.delete();
    run_reqs(40);
    repeat (8) @(posedge clk);
    #1;
    drain();
    chk("ref_count_min", ar_cyc.size() >= 8, 1);
    for (int i = 1; i < ar_cyc.size(); i++)
      chk("ref_gap", (ar_cyc[i] - ar_cyc[i-1] >= 12) && (ar_cyc[i] - ar_cyc[i-1] <= 20), 1);

    // random requests under random back-pressure
    stop_full = 0;
    fork
      begin
        run_reqs(30);
        stop_full = 1;
      end
      begin
        while (!stop_full) begin
          @(posedge clk);
          #1;
          bus.cba_full = ($urandom_range(0, 3) == 0);
        end
        bus.cba_full = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    drain();

    // reset asserted while an ACT is being presented
    mon_en = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_adr   = 25'($urandom_range(0, 33554431) & ~3);
    t = 0;
    @(negedge clk);
    while (!(bus.cba_din[17:15] == 3'b011) && t < 100) begin
      @(negedge clk);
      t++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_cba_wr", bus.cba_wr, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_req_ack", bus.req_ack, 0);
    chk("midrst_cba_din", bus.cba_din, mk(7, 0, 0));
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    init_check();
    @(posedge clk);
    #1;
    mon_en = 1;
    run_reqs(5);
    repeat (8) @(posedge clk);
    #1;
    drain();

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("ack_count", acks, reqs);
    chk("no_stray_ack", bad_ack, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
